// File: rtl/axi_slv_pkg.sv
// Shared AXI response/burst encodings and engine state types for the AXI4 SRAM responder.
package axi_slv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} wr_state_t;
    typedef enum logic [1:0] {StRIdle, StRWait, StRData} rd_state_t;

    // Response encodings are ordered by severity, so the numeric max is the worst one.
    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Combinational beat-address helper: next burst address, memory word index and in-range flag.
module axi_slv_addr_gen
    import axi_slv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       MEM_WORDS = 4096,
    parameter int unsigned       IDX_W     = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              in_range_o
);

    localparam int unsigned     OFF_W    = $clog2(DATA_W / 8);
    localparam logic [ADDR_W:0] MemBytes = (ADDR_W + 1)'(MEM_WORDS) << OFF_W;

    logic [2:0]        sz;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] offset;

    always_comb begin
        sz          = (size_i > 3'd3) ? 3'd3 : size_i;
        step        = ADDR_W'(1) << sz;
        // WRAP is handled as INCR; only FIXED holds the address.
        next_addr_o = (burst_i == BURST_FIXED) ? addr_i : addr_i + step;
        offset      = addr_i - BASE_ADDR;
        // Truncating the word offset gives modulo-MEM_WORDS wrap (MEM_WORDS is a power of two).
        idx_o       = offset[OFF_W +: IDX_W];
        in_range_o  = ({1'b0, offset} < MemBytes);
    end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed register array; independent read and write engines.
// Define AXI_SLV_DECERR_EN to answer out-of-range beats with DECERR instead of wrapping.
module axi4_sram_slave
    import axi_slv_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       ID_W      = 4,
    parameter int unsigned       MEM_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned       RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                axi_aw_valid_i,
    output logic                axi_aw_ready_o,
    input  logic [ADDR_W-1:0]   axi_aw_addr_i,
    input  logic [ID_W-1:0]     axi_aw_id_i,
    input  logic [7:0]          axi_aw_len_i,
    input  logic [2:0]          axi_aw_size_i,
    input  logic [1:0]          axi_aw_burst_i,
    input  logic                axi_w_valid_i,
    output logic                axi_w_ready_o,
    input  logic [DATA_W-1:0]   axi_w_data_i,
    input  logic [DATA_W/8-1:0] axi_w_strb_i,
    input  logic                axi_w_last_i,
    output logic                axi_b_valid_o,
    input  logic                axi_b_ready_i,
    output logic [1:0]          axi_b_resp_o,
    output logic [ID_W-1:0]     axi_b_id_o,
    input  logic                axi_ar_valid_i,
    output logic                axi_ar_ready_o,
    input  logic [ADDR_W-1:0]   axi_ar_addr_i,
    input  logic [ID_W-1:0]     axi_ar_id_i,
    input  logic [7:0]          axi_ar_len_i,
    input  logic [2:0]          axi_ar_size_i,
    input  logic [1:0]          axi_ar_burst_i,
    output logic                axi_r_valid_o,
    input  logic                axi_r_ready_i,
    output logic [DATA_W-1:0]   axi_r_data_o,
    output logic [1:0]          axi_r_resp_o,
    output logic                axi_r_last_o,
    output logic [ID_W-1:0]     axi_r_id_o
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned WaitLast = (RD_LAT > 1) ? RD_LAT - 2 : 0;
`ifdef AXI_SLV_DECERR_EN
    localparam bit DecerrEn = 1'b1;
`else
    localparam bit DecerrEn = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [MEM_WORDS];

    // Write engine state
    wr_state_t         wr_state_q;
    logic              aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]        b_resp_q, wr_resp_q;
    logic [ID_W-1:0]   b_id_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q, wr_cnt_q;
    logic [2:0]        wr_size_q;
    logic [1:0]        wr_burst_q;
    logic [ADDR_W-1:0] wr_next_addr;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_in_range;
    logic              w_fire, wr_beat_last, mem_we;
    logic [1:0]        wr_resp_acc;

    // Read engine state
    rd_state_t         rd_state_q;
    logic              ar_ready_q, r_valid_q, r_last_q;
    logic [DATA_W-1:0] r_data_q;
    logic [1:0]        r_resp_q;
    logic [ID_W-1:0]   r_id_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [7:0]        rd_len_q, rd_cnt_q, rd_wait_q;
    logic [2:0]        rd_size_q;
    logic [1:0]        rd_burst_q;
    logic [ADDR_W-1:0] rd_cur_addr, rd_next_addr;
    logic [2:0]        rd_cur_size;
    logic [1:0]        rd_cur_burst;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_in_range, ar_fire, rd_load, rd_load_last;
    logic [DATA_W-1:0] rd_load_data;
    logic [1:0]        rd_load_resp;

    axi_slv_addr_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_wr_addr_gen (
        .addr_i     (wr_addr_q),
        .size_i     (wr_size_q),
        .burst_i    (wr_burst_q),
        .next_addr_o(wr_next_addr),
        .idx_o      (wr_idx),
        .in_range_o (wr_in_range)
    );

    axi_slv_addr_gen #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_WORDS(MEM_WORDS),
        .IDX_W    (IDX_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_rd_addr_gen (
        .addr_i     (rd_cur_addr),
        .size_i     (rd_cur_size),
        .burst_i    (rd_cur_burst),
        .next_addr_o(rd_next_addr),
        .idx_o      (rd_idx),
        .in_range_o (rd_in_range)
    );

    // ---------------- Write engine ----------------
    always_comb begin
        w_fire       = axi_w_valid_i && w_ready_q;
        wr_beat_last = (wr_cnt_q == wr_len_q);
        wr_resp_acc  = wr_resp_q;
        if (axi_w_last_i != wr_beat_last) begin
            wr_resp_acc = worst_resp(wr_resp_acc, RESP_SLVERR);
        end
        if (DecerrEn && !wr_in_range) begin
            wr_resp_acc = worst_resp(wr_resp_acc, RESP_DECERR);
        end
        mem_we = w_fire && (!DecerrEn || wr_in_range);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= StWIdle;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            b_id_q     <= '0;
            wr_resp_q  <= RESP_OKAY;
            wr_addr_q  <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_size_q  <= '0;
            wr_burst_q <= '0;
        end else begin
            case (wr_state_q)
                StWIdle: begin
                    aw_ready_q <= 1'b1;
                    if (aw_ready_q && axi_aw_valid_i) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        wr_addr_q  <= axi_aw_addr_i;
                        b_id_q     <= axi_aw_id_i;
                        wr_len_q   <= axi_aw_len_i;
                        wr_size_q  <= axi_aw_size_i;
                        wr_burst_q <= axi_aw_burst_i;
                        wr_cnt_q   <= '0;
                        wr_resp_q  <= RESP_OKAY;
                        wr_state_q <= StWData;
                    end
                end
                StWData: begin
                    if (w_fire) begin
                        wr_cnt_q  <= wr_cnt_q + 8'd1;
                        wr_addr_q <= wr_next_addr;
                        wr_resp_q <= wr_resp_acc;
                        // Burst length comes from AW len; w_last only feeds the error check.
                        if (wr_beat_last) begin
                            w_ready_q  <= 1'b0;
                            b_valid_q  <= 1'b1;
                            b_resp_q   <= wr_resp_acc;
                            wr_state_q <= StWResp;
                        end
                    end
                end
                StWResp: begin
                    if (axi_b_ready_i) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        wr_state_q <= StWIdle;
                    end
                end
                default: wr_state_q <= StWIdle;
            endcase
        end
    end

    // Memory has no reset so contents survive a mid-burst reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_w_strb_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= axi_w_data_i[8*b +: 8];
                end
            end
        end
    end

    // ---------------- Read engine ----------------
    // rd_addr_q always holds the address of the next beat to load into the R registers.
    always_comb begin
        ar_fire      = axi_ar_valid_i && ar_ready_q;
        rd_cur_addr  = (rd_state_q == StRIdle) ? axi_ar_addr_i  : rd_addr_q;
        rd_cur_size  = (rd_state_q == StRIdle) ? axi_ar_size_i  : rd_size_q;
        rd_cur_burst = (rd_state_q == StRIdle) ? axi_ar_burst_i : rd_burst_q;
        rd_load_last = (rd_state_q == StRIdle) ? (axi_ar_len_i == 8'd0) : (rd_cnt_q == rd_len_q);
        rd_load_data = (DecerrEn && !rd_in_range) ? '0 : mem_q[rd_idx];
        rd_load_resp = (DecerrEn && !rd_in_range) ? RESP_DECERR : RESP_OKAY;
        rd_load      = 1'b0;
        case (rd_state_q)
            StRIdle: rd_load = ar_fire && (RD_LAT <= 1);
            StRWait: rd_load = (rd_wait_q == 8'(WaitLast));
            StRData: rd_load = axi_r_ready_i && !r_last_q;
            default: rd_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= StRIdle;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_id_q     <= '0;
            rd_addr_q  <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
            rd_wait_q  <= '0;
            rd_size_q  <= '0;
            rd_burst_q <= '0;
        end else begin
            case (rd_state_q)
                StRIdle: begin
                    ar_ready_q <= 1'b1;
                    if (ar_fire) begin
                        ar_ready_q <= 1'b0;
                        r_id_q     <= axi_ar_id_i;
                        rd_len_q   <= axi_ar_len_i;
                        rd_size_q  <= axi_ar_size_i;
                        rd_burst_q <= axi_ar_burst_i;
                        rd_addr_q  <= axi_ar_addr_i;
                        rd_cnt_q   <= '0;
                        rd_wait_q  <= '0;
                        rd_state_q <= (RD_LAT <= 1) ? StRData : StRWait;
                    end
                end
                StRWait: begin
                    rd_wait_q <= rd_wait_q + 8'd1;
                    if (rd_load) begin
                        rd_state_q <= StRData;
                    end
                end
                StRData: begin
                    if (axi_r_ready_i && r_last_q) begin
                        r_valid_q  <= 1'b0;
                        r_last_q   <= 1'b0;
                        rd_cnt_q   <= '0;
                        ar_ready_q <= 1'b1;
                        rd_state_q <= StRIdle;
                    end
                end
                default: rd_state_q <= StRIdle;
            endcase
            if (rd_load) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_load_data;
                r_resp_q  <= rd_load_resp;
                r_last_q  <= rd_load_last;
                rd_addr_q <= rd_next_addr;
                rd_cnt_q  <= rd_cnt_q + 8'd1;
            end
        end
    end

    assign axi_aw_ready_o = aw_ready_q;
    assign axi_w_ready_o  = w_ready_q;
    assign axi_b_valid_o  = b_valid_q;
    assign axi_b_resp_o   = b_resp_q;
    assign axi_b_id_o     = b_id_q;
    assign axi_ar_ready_o = ar_ready_q;
    assign axi_r_valid_o  = r_valid_q;
    assign axi_r_data_o   = r_data_q;
    assign axi_r_resp_o   = r_resp_q;
    assign axi_r_last_o   = r_last_q;
    assign axi_r_id_o     = r_id_q;

endmodule
